// File: rtl/step_pkg.sv
// rtl/step_pkg.sv - shared state encoding and default timing constants for the step pulse generator
package step_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    DONE
  } state_t;

  localparam int PUL_HIGH_CYC  = 16;
  localparam int DIR_SETUP_CYC = 32;
  localparam int RAMP_START    = 4096;
  localparam int RAMP_STEP     = 64;

endpackage

// File: rtl/step_ramp.sv
// rtl/step_ramp.sv - per-step period for a trapezoidal accelerate/cruise/decelerate profile
module step_ramp #(
  parameter int PW         = 17,
  parameter int CNT_W      = 16,
  parameter int RAMP_START = step_pkg::RAMP_START,
  parameter int RAMP_STEP  = step_pkg::RAMP_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [PW-1:0]    i_start_eff,
  input  logic [PW-1:0]    i_floor,
  input  logic             i_step,
  input  logic [CNT_W-1:0] i_steps_left,
  output logic [PW-1:0]    o_period
);
  localparam logic [PW-1:0] START = PW'(RAMP_START);
  localparam logic [PW-1:0] STEP  = PW'(RAMP_STEP);

  logic [PW-1:0]    r_period;
  logic [CNT_W-1:0] r_ramp_cnt;
  logic [PW-1:0]    w_first;
  logic [PW-1:0]    w_cap;
  logic [PW-1:0]    w_slower;
  logic [PW-1:0]    w_faster;
  logic [PW:0]      w_up;

  assign w_first  = (START > i_start_eff) ? START : i_start_eff;
  assign w_cap    = (START > i_floor) ? START : i_floor;
  assign w_up     = {1'b0, r_period} + {1'b0, STEP};
  assign w_slower = (w_up > {1'b0, w_cap}) ? w_cap : w_up[PW-1:0];
  assign w_faster = ({1'b0, r_period} >= ({1'b0, i_floor} + {1'b0, STEP})) ?
                    (r_period - STEP) : i_floor;

  // i_steps_left is the count before this step's decrement, so the
  // deceleration mirrors exactly the number of accelerating steps taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_period   <= '0;
      r_ramp_cnt <= '0;
    end else if (i_start) begin
      r_period   <= w_first;
      r_ramp_cnt <= '0;
    end else if (i_step) begin
      if (i_steps_left <= r_ramp_cnt) begin
        r_period <= w_slower;
      end else if (r_period > i_floor) begin
        r_period   <= w_faster;
        r_ramp_cnt <= r_ramp_cnt + CNT_W'(1);
      end
    end
  end

  assign o_period = r_period;

endmodule

// File: rtl/step_pulse_gen.sv
// rtl/step_pulse_gen.sv - step/dir pulse generator with setup delay, abort and hold
// Define STEP_PULSE_GEN_RAMP_EN to build the trapezoidal acceleration profile.
module step_pulse_gen #(
  parameter int PUL_HIGH_CYC  = step_pkg::PUL_HIGH_CYC,
  parameter int DIR_SETUP_CYC = step_pkg::DIR_SETUP_CYC,
`ifdef STEP_PULSE_GEN_RAMP_EN
  parameter int RAMP_START    = step_pkg::RAMP_START,
  parameter int RAMP_STEP     = step_pkg::RAMP_STEP,
`endif
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [CNT_W-1:0] cmd_period,
  input  logic             cmd_dir,
  input  logic             cmd_mod,
  input  logic             abort,
  input  logic             hold,
  output logic             pul,
  output logic             dir,
  output logic             mod,
  output logic             ena,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left
);
  import step_pkg::*;

  localparam int            PW         = CNT_W + 1;
  localparam logic [PW-1:0] MIN_PERIOD = PW'(2 * PUL_HIGH_CYC);
  localparam logic [PW-1:0] SETUP_LD   = PW'(DIR_SETUP_CYC - 1);
  localparam logic [PW-1:0] HIGH_LD    = PW'(PUL_HIGH_CYC - 1);

  state_t           r_state;
  logic [PW-1:0]    r_timer;
  logic [PW-1:0]    r_eff_period;
  logic [CNT_W-1:0] r_steps_left;
  logic             r_abort_pend;
  logic             r_pul;
  logic             r_dir;
  logic             r_mod;
  logic             r_busy;
  logic             r_done;

  logic [PW-1:0]    w_cmd_period;
  logic [PW-1:0]    w_eff;
  logic [PW-1:0]    w_period;
  logic [PW-1:0]    w_low_ld;
  logic             w_accept;

  assign w_cmd_period = {1'b0, cmd_period};
  assign w_eff        = (w_cmd_period < MIN_PERIOD) ? MIN_PERIOD : w_cmd_period;
  assign w_accept     = cmd_valid && !r_busy;
  assign w_low_ld     = w_period - PW'(PUL_HIGH_CYC + 1);

`ifdef STEP_PULSE_GEN_RAMP_EN
  logic          w_step;
  logic [PW-1:0] w_ramp_period;

  assign w_step = (r_state == LOW) && !abort && (r_timer == '0) && (r_steps_left != '0);

  step_ramp #(
    .PW         (PW),
    .CNT_W      (CNT_W),
    .RAMP_START (RAMP_START),
    .RAMP_STEP  (RAMP_STEP)
  ) u_ramp (
    .clk          (clk),
    .rst          (rst),
    .i_start      (w_accept),
    .i_start_eff  (w_eff),
    .i_floor      (r_eff_period),
    .i_step       (w_step),
    .i_steps_left (r_steps_left),
    .o_period     (w_ramp_period)
  );

  assign w_period = w_ramp_period;
`else
  assign w_period = r_eff_period;
`endif

  // An abort seen during HIGH is remembered so the pulse keeps its full width.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_timer      <= '0;
      r_eff_period <= '0;
      r_steps_left <= '0;
      r_abort_pend <= 1'b0;
      r_pul        <= 1'b0;
      r_dir        <= 1'b0;
      r_mod        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_busy       <= 1'b1;
            r_abort_pend <= 1'b0;
            if (cmd_steps != '0) begin
              r_state      <= SETUP;
              r_timer      <= SETUP_LD;
              r_dir        <= cmd_dir;
              r_mod        <= cmd_mod;
              r_steps_left <= cmd_steps;
              r_eff_period <= w_eff;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (abort) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_timer <= '0;
          end else if (r_timer == '0) begin
            r_state      <= HIGH;
            r_pul        <= 1'b1;
            r_timer      <= HIGH_LD;
            r_steps_left <= r_steps_left - CNT_W'(1);
          end else begin
            r_timer <= r_timer - PW'(1);
          end
        end
        HIGH: begin
          if (abort) begin
            r_abort_pend <= 1'b1;
          end
          if (r_timer == '0) begin
            r_pul <= 1'b0;
            if (abort || r_abort_pend) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= LOW;
              r_timer <= w_low_ld;
            end
          end else begin
            r_timer <= r_timer - PW'(1);
          end
        end
        LOW: begin
          if (abort || ((r_timer == '0) && (r_steps_left == '0))) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_timer <= '0;
          end else if (r_timer == '0) begin
            r_state      <= HIGH;
            r_pul        <= 1'b1;
            r_timer      <= HIGH_LD;
            r_steps_left <= r_steps_left - CNT_W'(1);
          end else begin
            r_timer <= r_timer - PW'(1);
          end
        end
        DONE: begin
          r_state      <= IDLE;
          r_done       <= 1'b0;
          r_busy       <= 1'b0;
          r_abort_pend <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_pul   <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = !r_busy;
  assign pul        = r_pul;
  assign dir        = r_dir;
  assign mod        = r_mod;
  assign busy       = r_busy;
  assign ena        = r_busy | hold;
  assign done       = r_done;
  assign steps_left = r_steps_left;

endmodule

// File: tb/tb_step_pulse_gen.sv
// tb/tb_step_pulse_gen.sv - scoreboard bench for step_pulse_gen (pulse width/period, abort, reset, ramp)
module tb_step_pulse_gen;
  localparam int CNT_W = 16;

  logic             clk        = 1'b0;
  logic             rst        = 1'b1;
  logic             cmd_valid  = 1'b0;
  logic             cmd_dir    = 1'b0;
  logic             cmd_mod    = 1'b0;
  logic             abort      = 1'b0;
  logic             hold       = 1'b0;
  logic [CNT_W-1:0] cmd_steps  = '0;
  logic [CNT_W-1:0] cmd_period = '0;
  logic             cmd_ready;
  logic             pul, dir, mod, ena, busy, done;
  logic [CNT_W-1:0] steps_left;

  always #5 clk = ~clk;

  step_pulse_gen #(
    .PUL_HIGH_CYC  (16),
    .DIR_SETUP_CYC (32),
`ifdef STEP_PULSE_GEN_RAMP_EN
    .RAMP_START    (400),
    .RAMP_STEP     (100),
`endif
    .CNT_W         (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_steps  (cmd_steps),
    .cmd_period (cmd_period),
    .cmd_dir    (cmd_dir),
    .cmd_mod    (cmd_mod),
    .abort      (abort),
    .hold       (hold),
    .pul        (pul),
    .dir        (dir),
    .mod        (mod),
    .ena        (ena),
    .busy       (busy),
    .done       (done),
    .steps_left (steps_left)
  );

  typedef struct {
    int hi;
    int lo;
  } pulse_t;

  pulse_t exp_q[$];
  pulse_t obs_q[$];
  int     n_checks = 0;
  int     n_pass   = 0;
  int     obs_setup;
  logic   obs_done;
  logic   obs_timeout;
  logic   obs_dir;
  logic   exp_dir = 1'b0;
  logic   exp_mod = 1'b0;

  function automatic void expect_pulse(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) exp_q.push_back('{hi, lo});
  endfunction

  task automatic send_cmd(input int s, input int p, input logic d, input logic m);
    @(negedge clk);
    cmd_steps  = CNT_W'(s);
    cmd_period = CNT_W'(p);
    cmd_dir    = d;
    cmd_mod    = m;
    cmd_valid  = 1'b1;
    if (s != 0) begin
      exp_dir = d;
      exp_mod = m;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Records each pulse as (high cycles, low cycles) until done or busy drops.
  // act_pulse 0 targets the setup phase, k>=1 pulse k; act_low picks its low phase.
  task automatic capture(input int budget, input int act_pulse, input bit act_low,
                         input int act_after, input bit act_rst);
    int hi = 0, lo = 0, npulse = 0, cnt;
    bit in_high = 1'b0, fired = 1'b0;
    obs_q.delete();
    obs_setup   = 0;
    obs_done    = 1'b0;
    obs_timeout = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      abort = 1'b0;
      if (c == 0) obs_dir = dir;
      if (done || !busy) begin
        if (npulse > 0) obs_q.push_back('{hi, in_high ? 0 : lo});
        obs_done    = done;
        obs_timeout = 1'b0;
        break;
      end
      if (pul) begin
        if (!in_high) begin
          if (npulse > 0) obs_q.push_back('{hi, lo});
          npulse++;
          hi      = 0;
          lo      = 0;
          in_high = 1'b1;
        end
        hi++;
      end else begin
        in_high = 1'b0;
        if (npulse > 0) lo++;
        else obs_setup++;
      end
      cnt = (act_pulse == 0) ? obs_setup :
            act_low ? (in_high ? -1 : lo) : (in_high ? hi : -1);
      if (!fired && act_pulse >= 0 && npulse == act_pulse && cnt == act_after) begin
        fired = 1'b1;
        if (act_rst) rst = 1'b1;
        else abort = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({pul, dir, mod, ena, busy, done} !== 6'b0 || steps_left !== '0)
      $display("FAIL reset_outputs got pul/dir/mod/ena/busy/done=%b steps_left=%0d required 000000 and 0",
               {pul, dir, mod, ena, busy, done}, steps_left);
    else n_pass++;
    rst  = 1'b0;
    hold = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ena, busy} !== 2'b10) $display("FAIL hold_ena got ena/busy=%b required 10", {ena, busy});
    else n_pass++;
    hold = 1'b0;
  endtask

  task automatic test_zero_steps();
    send_cmd(0, 100, ~exp_dir, ~exp_mod);
    capture(100, -1, 1'b0, 0, 1'b0);
    n_checks++;
    if (obs_done !== 1'b1 || obs_setup != 0)
      $display("FAIL zero_done got done=%b setup=%0d required done=1 setup=0", obs_done, obs_setup);
    else n_pass++;
    n_checks++;
    if (dir !== exp_dir || mod !== exp_mod)
      $display("FAIL zero_dirmod got dir=%b mod=%b required dir=%b mod=%b", dir, mod, exp_dir, exp_mod);
    else n_pass++;
    n_checks++;
    if (obs_q.size() != 0) $display("FAIL zero_nopulse got %0d pulses required 0", obs_q.size());
    else n_pass++;
  endtask

`ifndef STEP_PULSE_GEN_RAMP_EN
  task automatic test_basic();
    pulse_t e, o;
    expect_pulse(3, 16, 84);
    send_cmd(3, 100, 1'b1, 1'b0);
    capture(3000, -1, 1'b0, 0, 1'b0);
    n_checks++;
    if (obs_dir !== 1'b1 || obs_setup != 32)
      $display("FAIL basic_setup got dir=%b setup=%0d required dir=1 setup=32", obs_dir, obs_setup);
    else n_pass++;
    n_checks++;
    if (obs_done !== 1'b1 || obs_timeout !== 1'b0)
      $display("FAIL basic_done got done=%b timeout=%b required done=1 timeout=0", obs_done, obs_timeout);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL basic_pulse missing, required hi=%0d lo=%0d", e.hi, e.lo);
      else begin
        o = obs_q.pop_front();
        if (o.hi != e.hi || o.lo != e.lo)
          $display("FAIL basic_pulse got hi=%0d lo=%0d required hi=%0d lo=%0d", o.hi, o.lo, e.hi, e.lo);
        else n_pass++;
      end
    end
    n_checks++;
    if (obs_q.size() != 0) $display("FAIL basic_extra got %0d extra pulses required 0", obs_q.size());
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({done, busy} !== 2'b00) $display("FAIL basic_done_width got done/busy=%b required 00", {done, busy});
    else n_pass++;
  endtask

  task automatic test_min_period();
    pulse_t e, o;
    expect_pulse(2, 16, 16);
    send_cmd(2, 10, 1'b0, 1'b0);
    capture(3000, -1, 1'b0, 0, 1'b0);
    n_checks++;
    if (obs_done !== 1'b1 || obs_dir !== 1'b0)
      $display("FAIL minp_done got done=%b dir=%b required done=1 dir=0", obs_done, obs_dir);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL minp_pulse missing, required hi=%0d lo=%0d", e.hi, e.lo);
      else begin
        o = obs_q.pop_front();
        if (o.hi != e.hi || o.lo != e.lo)
          $display("FAIL minp_pulse got hi=%0d lo=%0d required hi=%0d lo=%0d", o.hi, o.lo, e.hi, e.lo);
        else n_pass++;
      end
    end
  endtask

  task automatic test_busy_ignore();
    pulse_t e, o;
    expect_pulse(2, 16, 24);
    send_cmd(2, 40, 1'b1, 1'b1);
    cmd_valid  = 1'b1;
    cmd_steps  = CNT_W'(7);
    cmd_period = CNT_W'(50);
    cmd_dir    = 1'b0;
    cmd_mod    = 1'b0;
    capture(3000, -1, 1'b0, 0, 1'b0);
    cmd_valid = 1'b0;
    n_checks++;
    if (obs_done !== 1'b1 || dir !== exp_dir || mod !== exp_mod)
      $display("FAIL busy_ignore_dir got done=%b dir=%b mod=%b required 1 %b %b",
               obs_done, dir, mod, exp_dir, exp_mod);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL busy_ignore_pulse missing, required hi=%0d lo=%0d", e.hi, e.lo);
      else begin
        o = obs_q.pop_front();
        if (o.hi != e.hi || o.lo != e.lo)
          $display("FAIL busy_ignore_pulse got hi=%0d lo=%0d required hi=%0d lo=%0d", o.hi, o.lo, e.hi, e.lo);
        else n_pass++;
      end
    end
    n_checks++;
    if (obs_q.size() != 0) $display("FAIL busy_ignore_extra got %0d extra pulses required 0", obs_q.size());
    else n_pass++;
  endtask

  task automatic test_abort_high();
    pulse_t e, o;
    exp_q.push_back('{16, 84});
    exp_q.push_back('{16, 0});
    send_cmd(10, 100, 1'b1, 1'b0);
    capture(3000, 2, 1'b0, 5, 1'b0);
    n_checks++;
    if (obs_done !== 1'b1 || steps_left !== CNT_W'(8))
      $display("FAIL abort_high_done got done=%b steps_left=%0d required done=1 steps_left=8", obs_done, steps_left);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL abort_high_pulse missing, required hi=%0d lo=%0d", e.hi, e.lo);
      else begin
        o = obs_q.pop_front();
        if (o.hi != e.hi || o.lo != e.lo)
          $display("FAIL abort_high_pulse got hi=%0d lo=%0d required hi=%0d lo=%0d", o.hi, o.lo, e.hi, e.lo);
        else n_pass++;
      end
    end
  endtask

  task automatic test_abort_setup_low();
    pulse_t e, o;
    send_cmd(4, 64, 1'b0, 1'b0);
    capture(3000, 0, 1'b0, 3, 1'b0);
    n_checks++;
    if (obs_done !== 1'b1 || obs_setup != 3 || obs_q.size() != 0 || steps_left !== CNT_W'(4))
      $display("FAIL abort_setup got done=%b setup=%0d pulses=%0d steps_left=%0d required 1 3 0 4",
               obs_done, obs_setup, obs_q.size(), steps_left);
    else n_pass++;
    exp_q.push_back('{16, 10});
    send_cmd(4, 64, 1'b0, 1'b0);
    capture(3000, 1, 1'b1, 10, 1'b0);
    n_checks++;
    if (obs_done !== 1'b1 || steps_left !== CNT_W'(3))
      $display("FAIL abort_low_done got done=%b steps_left=%0d required done=1 steps_left=3", obs_done, steps_left);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL abort_low_pulse missing, required hi=%0d lo=%0d", e.hi, e.lo);
      else begin
        o = obs_q.pop_front();
        if (o.hi != e.hi || o.lo != e.lo)
          $display("FAIL abort_low_pulse got hi=%0d lo=%0d required hi=%0d lo=%0d", o.hi, o.lo, e.hi, e.lo);
        else n_pass++;
      end
    end
  endtask

  task automatic test_rst_low();
    pulse_t e, o;
    exp_q.push_back('{16, 48});
    exp_q.push_back('{16, 10});
    send_cmd(5, 64, 1'b1, 1'b1);
    capture(3000, 2, 1'b1, 10, 1'b1);
    exp_dir = 1'b0;
    exp_mod = 1'b0;
    n_checks++;
    if (obs_timeout !== 1'b0 || obs_done !== 1'b0 || {pul, dir, mod, ena, busy, done} !== 6'b0 || steps_left !== '0)
      $display("FAIL rst_low_outputs got timeout=%b done_seen=%b outs=%b steps_left=%0d required 0 0 000000 0",
               obs_timeout, obs_done, {pul, dir, mod, ena, busy, done}, steps_left);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL rst_low_pulse missing, required hi=%0d lo=%0d", e.hi, e.lo);
      else begin
        o = obs_q.pop_front();
        if (o.hi != e.hi || o.lo != e.lo)
          $display("FAIL rst_low_pulse got hi=%0d lo=%0d required hi=%0d lo=%0d", o.hi, o.lo, e.hi, e.lo);
        else n_pass++;
      end
    end
    rst = 1'b0;
    exp_q.push_back('{16, 16});
    send_cmd(1, 32, 1'b1, 1'b0);
    capture(3000, -1, 1'b0, 0, 1'b0);
    n_checks++;
    if (obs_done !== 1'b1 || obs_setup != 32 || obs_dir !== 1'b1)
      $display("FAIL rst_recover got done=%b setup=%0d dir=%b required 1 32 1", obs_done, obs_setup, obs_dir);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL rst_recover_pulse missing, required hi=%0d lo=%0d", e.hi, e.lo);
      else begin
        o = obs_q.pop_front();
        if (o.hi != e.hi || o.lo != e.lo)
          $display("FAIL rst_recover_pulse got hi=%0d lo=%0d required hi=%0d lo=%0d", o.hi, o.lo, e.hi, e.lo);
        else n_pass++;
      end
    end
  endtask
`else
  task automatic test_ramp();
    pulse_t e, o;
    int periods [6] = '{400, 300, 200, 200, 300, 400};
    foreach (periods[i]) exp_q.push_back('{16, periods[i] - 16});
    send_cmd(6, 200, 1'b1, 1'b0);
    capture(5000, -1, 1'b0, 0, 1'b0);
    n_checks++;
    if (obs_done !== 1'b1 || obs_setup != 32)
      $display("FAIL ramp_done got done=%b setup=%0d required done=1 setup=32", obs_done, obs_setup);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL ramp_pulse missing, required hi=%0d lo=%0d", e.hi, e.lo);
      else begin
        o = obs_q.pop_front();
        if (o.hi != e.hi || o.lo != e.lo)
          $display("FAIL ramp_pulse got hi=%0d lo=%0d required hi=%0d lo=%0d", o.hi, o.lo, e.hi, e.lo);
        else n_pass++;
      end
    end
    n_checks++;
    if (obs_q.size() != 0) $display("FAIL ramp_extra got %0d extra pulses required 0", obs_q.size());
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
`ifdef STEP_PULSE_GEN_RAMP_EN
    test_zero_steps();
    test_ramp();
`else
    test_basic();
    test_zero_steps();
    test_min_period();
    test_busy_ignore();
    test_abort_high();
    test_abort_setup_low();
    test_rst_low();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
